char_buffer_arbiter: RTL and testbench

Shares the single-port character RAM between the VGA character fetch path and a writer (UART/lab logic) with valid/ready handshake. Also runs a clear-screen sequence that fills the buffer with a blank character. Sits between the vga timing generator (x, y, display_on) and the character RAM / font lookup inside common_top. Display fetch has absolute priority so the picture never tears.

---
 rtl/char_buffer_pkg.sv | 29 ++
 rtl/char_cell_addr.sv | 37 +++
 rtl/char_buffer_arbiter.sv | 141 ++++++++++++++
 tb/tb_char_buffer_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/char_buffer_pkg.sv
// Shared geometry, widths and FSM encoding for the character buffer arbiter.
// Derived sizes follow from the screen and cell dimensions.
package char_buffer_pkg;

    localparam int unsigned CLK_MHZ       = 50;
    localparam int unsigned SCREEN_WIDTH  = 640;
    localparam int unsigned SCREEN_HEIGHT = 480;
    localparam int unsigned CHAR_W        = 8;
    localparam int unsigned CHAR_H        = 16;
    localparam int unsigned W_CHAR        = 8;

    localparam logic [W_CHAR-1:0] CLEAR_CHAR = 8'h20;

    localparam int unsigned W_X         = $clog2(SCREEN_WIDTH);
    localparam int unsigned W_Y         = $clog2(SCREEN_HEIGHT);
    localparam int unsigned LOG2_CHAR_W = $clog2(CHAR_W);
    localparam int unsigned LOG2_CHAR_H = $clog2(CHAR_H);

    localparam int unsigned COLS   = SCREEN_WIDTH / CHAR_W;
    localparam int unsigned ROWS   = SCREEN_HEIGHT / CHAR_H;
    localparam int unsigned DEPTH  = COLS * ROWS;
    localparam int unsigned W_ADDR = $clog2(DEPTH);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

endpackage

// File: rtl/char_cell_addr.sv
// Combinational pixel (x,y) to character cell index, row*COLS + col,
// built from constant shifts and adds so no multiplier is inferred.
module char_cell_addr
    import char_buffer_pkg::*;
(
    input  logic [W_X-1:0]    i_x,
    input  logic [W_Y-1:0]    i_y,
    output logic [W_ADDR-1:0] o_cell
);

    localparam int unsigned W_COL = W_X - LOG2_CHAR_W;
    localparam int unsigned W_ROW = W_Y - LOG2_CHAR_H;

    logic [W_COL-1:0]  w_col;
    logic [W_ROW-1:0]  w_row;
    logic [W_ADDR-1:0] w_row_base;
    logic              w_unused_lsbs;

    assign w_col = i_x[W_X-1:LOG2_CHAR_W];
    assign w_row = i_y[W_Y-1:LOG2_CHAR_H];

    // Sub-cell pixel offsets do not affect the cell index.
    assign w_unused_lsbs = ^{i_x[LOG2_CHAR_W-1:0], i_y[LOG2_CHAR_H-1:0]};

    // One shifted copy of the row per set bit of COLS (80 = 64 + 16).
    always_comb begin
        w_row_base = '0;
        for (int unsigned b = 0; b < W_ADDR; b++) begin
            if (COLS[b]) begin
                w_row_base = w_row_base + (W_ADDR'(w_row) << b);
            end
        end
    end

    assign o_cell = w_row_base + W_ADDR'(w_col);

endmodule

// File: rtl/char_buffer_arbiter.sv
// Arbitrates the single-port character RAM between display fetch (highest
// priority), a valid/ready writer and a clear-screen fill sequence.
module char_buffer_arbiter
    import char_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              display_on,
    input  logic [W_X-1:0]    x,
    input  logic [W_Y-1:0]    y,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [W_ADDR-1:0] wr_addr,
    input  logic [W_CHAR-1:0] wr_data,
    input  logic              clear_req,
    output logic              busy,
    output logic [W_CHAR-1:0] char_code,
    output logic              char_valid,
    output logic [W_ADDR-1:0] mem_addr,
    output logic              mem_we,
    output logic [W_CHAR-1:0] mem_wdata,
    input  logic [W_CHAR-1:0] mem_rdata
);

    state_t            r_state;
    state_t            w_state_next;
    logic [W_ADDR-1:0] r_clr_cnt;
    logic [W_ADDR-1:0] w_clr_cnt_next;
    logic              w_clr_issue;

    logic [W_X-1:0]    r_x_prev;
    logic              w_trigger;
    logic [W_ADDR-1:0] w_cell;
    logic              r_fetch_d1;
    logic              r_fetch_d2;

    logic              w_wr_accept;
    logic              w_wr_in_range;

    logic [W_ADDR-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [W_CHAR-1:0] r_mem_wdata;
    logic [W_CHAR-1:0] r_char_code;
    logic              r_char_valid;

    char_cell_addr u_cell_addr (
        .i_x    (x),
        .i_y    (y),
        .o_cell (w_cell)
    );

    // A fetch is due on the first clk of each new cell column; x holds for 2 clk.
    assign w_trigger = display_on
                    && (x[LOG2_CHAR_W-1:0] == '0)
                    && (x != r_x_prev);

    assign wr_ready      = !rst && (r_state == IDLE) && !w_trigger;
    assign w_wr_accept   = wr_valid && wr_ready;
    assign w_wr_in_range = (wr_addr < W_ADDR'(DEPTH));
    assign busy          = (r_state == CLEAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_cnt <= w_clr_cnt_next;
        end
    end

    // Clear stalls on fetch cycles so no cell is skipped or written twice.
    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        w_clr_issue    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (clear_req) begin
                    w_state_next   = CLEAR;
                    w_clr_cnt_next = '0;
                end
            end
            CLEAR: begin
                if (!w_trigger) begin
                    w_clr_issue = 1'b1;
                    if (r_clr_cnt == W_ADDR'(DEPTH - 1)) begin
                        w_state_next   = IDLE;
                        w_clr_cnt_next = '0;
                    end else begin
                        w_clr_cnt_next = r_clr_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x_prev     <= '1;
            r_fetch_d1   <= 1'b0;
            r_fetch_d2   <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= '0;
            r_char_code  <= '0;
            r_char_valid <= 1'b0;
        end else begin
            r_x_prev     <= x;
            r_fetch_d1   <= w_trigger;
            r_fetch_d2   <= r_fetch_d1;
            r_char_valid <= r_fetch_d2;
            if (r_fetch_d2) begin
                r_char_code <= mem_rdata;
            end

            r_mem_we <= 1'b0;
            if (w_trigger) begin
                r_mem_addr <= w_cell;
            end else if (w_clr_issue) begin
                r_mem_we    <= 1'b1;
                r_mem_addr  <= r_clr_cnt;
                r_mem_wdata <= CLEAR_CHAR;
            end else if (w_wr_accept && w_wr_in_range) begin
                r_mem_we    <= 1'b1;
                r_mem_addr  <= wr_addr;
                r_mem_wdata <= wr_data;
            end
        end
    end

    assign mem_addr   = r_mem_addr;
    assign mem_we     = r_mem_we;
    assign mem_wdata  = r_mem_wdata;
    assign char_code  = r_char_code;
    assign char_valid = r_char_valid;

endmodule

// File: tb/tb_char_buffer_arbiter.sv
// Scoreboard bench for char_buffer_arbiter with a behavioural 1-cycle RAM.
module tb_char_buffer_arbiter;
    import char_buffer_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              display_on;
    logic [W_X-1:0]    x;
    logic [W_Y-1:0]    y;
    logic              wr_valid;
    logic              wr_ready;
    logic [W_ADDR-1:0] wr_addr;
    logic [W_CHAR-1:0] wr_data;
    logic              clear_req;
    logic              busy;
    logic [W_CHAR-1:0] char_code;
    logic              char_valid;
    logic [W_ADDR-1:0] mem_addr;
    logic              mem_we;
    logic [W_CHAR-1:0] mem_wdata;
    logic [W_CHAR-1:0] mem_rdata;

    always #10 clk = ~clk;

    char_buffer_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .display_on (display_on),
        .x          (x),
        .y          (y),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .clear_req  (clear_req),
        .busy       (busy),
        .char_code  (char_code),
        .char_valid (char_valid),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    typedef struct packed {
        logic [W_ADDR-1:0] addr;
        logic [W_CHAR-1:0] data;
    } wr_t;

    logic [W_CHAR-1:0] ram [DEPTH];
    logic              fill_req = 1'b0;
    wr_t               wq[$];
    logic [W_CHAR-1:0] fq[$];
    int                checks = 0;
    int                errors = 0;
    int unsigned       n_writes = 0;
    bit                fetch_chk = 1'b1;
    wr_t               e_wr;
    logic [W_CHAR-1:0] e_ch;

    function automatic logic [W_CHAR-1:0] pattern(int unsigned i);
        return 8'((i * 7 + 3) ^ (i >> 8));
    endfunction

    always @(posedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= pattern(i);
        end else if (mem_we && (mem_addr < W_ADDR'(DEPTH))) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            n_writes++;
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL sb_write: got addr=%0d data=%h, expected no write", mem_addr, mem_wdata);
            end else begin
                e_wr = wq.pop_front();
                if ({mem_addr, mem_wdata} !== e_wr) begin
                    errors++;
                    $display("FAIL sb_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                             mem_addr, mem_wdata, e_wr.addr, e_wr.data);
                end
            end
        end
        if (char_valid === 1'b1 && fetch_chk) begin
            checks++;
            if (fq.size() == 0) begin
                errors++;
                $display("FAIL sb_fetch: got char_valid with code=%h, expected none", char_code);
            end else begin
                e_ch = fq.pop_front();
                if (char_code !== e_ch) begin
                    errors++;
                    $display("FAIL sb_fetch: got code=%h, expected %h", char_code, e_ch);
                end
            end
        end
    end

    task automatic fill_ram();
        @(posedge clk); #1 fill_req = 1'b1;
        @(posedge clk); #1 fill_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; display_on = 1'b0; x = '0; y = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0; clear_req = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++; $display("FAIL reset_wr_ready: got %b, expected 0 while rst", wr_ready);
        end
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_we, char_valid, busy, wr_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_flags: got we/cv/busy/rdy=%b%b%b%b, expected 0001",
                     mem_we, char_valid, busy, wr_ready);
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0 || char_code !== '0) begin
            errors++;
            $display("FAIL reset_regs: got addr=%0d wdata=%h code=%h, expected 0 0 0",
                     mem_addr, mem_wdata, char_code);
        end
    endtask

    task automatic test_write();
        int unsigned base;
        @(posedge clk); #1 wr_valid = 1'b1; wr_addr = 12'd5; wr_data = 8'h41;
        wq.push_back('{addr: 12'd5, data: 8'h41});
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++; $display("FAIL write_ready: got %b, expected 1", wr_ready);
        end
        @(posedge clk); #1 wr_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'd5, 8'h41}) begin
            errors++;
            $display("FAIL write_issue: got we=%b addr=%0d data=%h, expected 1 5 41",
                     mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b0) begin
            errors++; $display("FAIL write_pulse: got mem_we=%b, expected 0", mem_we);
        end
        // Out-of-range address: accepted but never written.
        base = n_writes;
        @(posedge clk); #1 wr_valid = 1'b1; wr_addr = 12'd2400; wr_data = 8'h77;
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++; $display("FAIL write_oor_ready: got %b, expected 1", wr_ready);
        end
        @(posedge clk); #1 wr_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (n_writes != base) begin
            errors++; $display("FAIL write_oor_drop: got %0d writes, expected 0", n_writes - base);
        end
    endtask

    task automatic do_fetch(input logic [W_Y-1:0] yy, input logic [W_X-1:0] x0,
                            input logic [W_X-1:0] x1, input logic [W_ADDR-1:0] exp_addr);
        @(posedge clk); #1 display_on = 1'b1; y = yy; x = x0;
        @(posedge clk); #1 x = x1;
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++; $display("FAIL fetch_block_ready: got %b, expected 0", wr_ready);
        end
        @(negedge clk);
        checks++;
        if (mem_addr !== exp_addr || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL fetch_addr: got addr=%0d we=%b, expected %0d 0", mem_addr, mem_we, exp_addr);
        end
        fq.push_back(ram[exp_addr]);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (char_valid !== 1'b1) begin
            errors++; $display("FAIL fetch_latency: got char_valid=%b at T+3, expected 1", char_valid);
        end
        @(negedge clk);
        checks++;
        if (char_valid !== 1'b0) begin
            errors++; $display("FAIL fetch_strobe: got char_valid=%b at T+4, expected 0", char_valid);
        end
    endtask

    task automatic test_fetch();
        fill_ram();
        do_fetch(9'd32, 10'd15, 10'd16, 12'd162);
        do_fetch(9'd479, 10'd631, 10'd632, 12'd2399);
        #1 display_on = 1'b0;
    endtask

    task automatic test_back_to_back();
        int unsigned base;
        @(posedge clk); #1 display_on = 1'b1; y = 9'd32; x = 10'd23;
        base = n_writes;
        @(posedge clk); #1 x = 10'd24; wr_valid = 1'b1; wr_addr = 12'd300; wr_data = 8'h55;
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_stall: got wr_ready=%b on fetch cycle, expected 0", wr_ready);
        end
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b1 || mem_addr !== 12'd163 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: got rdy=%b addr=%0d we=%b, expected 1 163 0", wr_ready, mem_addr, mem_we);
        end
        fq.push_back(ram[163]);
        wq.push_back('{addr: 12'd300, data: 8'h55});
        @(posedge clk); #1 wr_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (n_writes - base != 1 || ram[300] !== 8'h55) begin
            errors++;
            $display("FAIL b2b_once: got %0d writes ram[300]=%h, expected 1 55", n_writes - base, ram[300]);
        end
        display_on = 1'b0;
    endtask

    task automatic run_clear(input bit vid, output int unsigned busy_cycles);
        bit done = 1'b0;
        int unsigned bad = 0;
        for (int i = 0; i < DEPTH; i++) wq.push_back('{addr: W_ADDR'(i), data: 8'h20});
        @(posedge clk); #1 clear_req = 1'b1;
        @(posedge clk); #1;
        busy_cycles = 0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) begin
                done = 1'b1;
                break;
            end
            busy_cycles++;
            if (i == 5) begin
                checks++;
                if (wr_ready !== 1'b0) begin
                    errors++; $display("FAIL clear_ready: got wr_ready=%b in CLEAR, expected 0", wr_ready);
                end
            end
            @(posedge clk); #1;
            if (i == 2) clear_req = 1'b0;
            if (vid && i[0]) x = (x == 10'd639) ? '0 : x + 10'd1;
        end
        checks++;
        if (!done) begin
            errors++; $display("FAIL clear_timeout: got busy still 1 after 6000 cycles, expected 0");
        end
        display_on = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < DEPTH; i++) if (ram[i] !== 8'h20) bad++;
        checks++;
        if (wq.size() != 0 || bad != 0) begin
            errors++;
            $display("FAIL clear_fill: got %0d pending writes %0d bad cells, expected 0 0", wq.size(), bad);
        end
    endtask

    task automatic test_clear();
        int unsigned bc;
        fill_ram();
        run_clear(1'b0, bc);
        checks++;
        if (bc != DEPTH) begin
            errors++; $display("FAIL clear_busy_len: got %0d busy cycles, expected 2400", bc);
        end
        fill_ram();
        fetch_chk = 1'b0;
        @(posedge clk); #1 display_on = 1'b1; y = 9'd32; x = 10'd1;
        run_clear(1'b1, bc);
        fetch_chk = 1'b1;
        checks++;
        if (bc <= DEPTH || bc > 2600) begin
            errors++; $display("FAIL clear_video_len: got %0d busy cycles, expected 2401..2600", bc);
        end
    endtask

    task automatic test_reset_mid_clear();
        int unsigned bad = 0;
        fill_ram();
        display_on = 1'b0;
        for (int i = 0; i < 1000; i++) wq.push_back('{addr: W_ADDR'(i), data: 8'h20});
        @(posedge clk); #1 clear_req = 1'b1;
        @(posedge clk); #1 clear_req = 1'b0;
        repeat (1000) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 12'd999) begin
            errors++;
            $display("FAIL rstclr_pre: got busy=%b we=%b addr=%0d, expected 1 1 999", busy, mem_we, mem_addr);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_we !== 1'b0) begin
            errors++; $display("FAIL rstclr_post: got busy=%b we=%b, expected 0 0", busy, mem_we);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL rstclr_idle: got rdy=%b busy=%b, expected 1 0", wr_ready, busy);
        end
        for (int i = 1000; i < DEPTH; i++) if (ram[i] !== pattern(i)) bad++;
        checks++;
        if (wq.size() != 0 || ram[999] !== 8'h20 || bad != 0) begin
            errors++;
            $display("FAIL rstclr_ram: got pending=%0d ram[999]=%h changed_tail=%0d, expected 0 20 0",
                     wq.size(), ram[999], bad);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_fetch();
        test_back_to_back();
        test_clear();
        test_reset_mid_clear();
        repeat (4) @(negedge clk);
        checks++;
        if (fq.size() != 0) begin
            errors++; $display("FAIL fetch_drain: got %0d pending fetches, expected 0", fq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got simulation still running at 2ms, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
